// File: rtl/uart_pkg.sv
// Shared UART definitions for the pc_one receive and transmit paths.
// Baud defaults live here so both ends of the link agree.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 104;
    localparam int DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
// The reset value is chosen per input (idle level of the line).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_from_FPGA,
    input  logic rst_from_FPGA,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two back-to-back flops; dout is safe to use in the core domain.
    always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
        if (!rst_from_FPGA) begin
            meta <= RST_VAL;
            dout <= RST_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-deep holding register.
// Frame and overrun errors are reported as single-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk_from_FPGA,
    input  logic                 rst_from_FPGA,
    input  logic                 uart_rx_pin_for_FPGA,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 rxs, rxs_q;
    logic                 done_q, done_d;
    logic                 ferr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_from_FPGA (clk_from_FPGA),
        .rst_from_FPGA (rst_from_FPGA),
        .din           (uart_rx_pin_for_FPGA),
        .dout          (rxs)
    );

    assign busy = (state_q != IDLE);

    // Frame sequencing: start check, data shifting, stop check.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rxs_q && !rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                    sh_d  = (sh_q >> 1)
                          | (DATA_BITS'(rxs) << (DATA_BITS - 1));
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HIGH;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receiver state, counters, shift register and edge-detect history.
    always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
        if (!rst_from_FPGA) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            rxs_q     <= 1'b1;
            done_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            rxs_q     <= rxs;
            done_q    <= done_d;
            frame_err <= ferr_d;
        end
    end

    // Holding register: load a finished byte unless it would clobber one.
    always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
        if (!rst_from_FPGA) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= sh_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
